// File: rtl/dct_tile_pkg.sv
// Shared constants, state encoding and block element indexing for the dct2d
// window tiler and the block reassembler.
package dct_tile_pkg;

  localparam int N       = 16;
  localparam int BLK     = 8;
  localparam int IMG_W   = 128;
  localparam int IMG_H   = 128;
  localparam int BPR     = IMG_W / BLK;
  localparam int STRIPES = IMG_H / BLK;

  // Counter width that stays legal for a count of one.
  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Element (r,c) of a flattened block lives at slice elem_idx(r,c)*N +: N.
  function automatic int elem_idx(input int r, input int c);
    return 63 - (BLK * r + c);
  endfunction

endpackage

// File: rtl/dct_block_reassembler_if.sv
// Block-in / pixel-out handshake bundle of the block reassembler.
// master = block source and pixel sink, slave = the reassembler.
interface dct_block_reassembler_if #(
  parameter int N = 16
);
  logic            blk_valid;
  logic            blk_ready;
  logic [64*N-1:0] blk_data;
  logic            pix_valid;
  logic            pix_ready;
  logic [N-1:0]    pix_data;
  logic            pix_eol;
  logic            pix_eof;
  logic            frame_done;

  modport master (
    output blk_valid, blk_data, pix_ready,
    input  blk_ready, pix_valid, pix_data, pix_eol, pix_eof, frame_done
  );

  modport slave (
    input  blk_valid, blk_data, pix_ready,
    output blk_ready, pix_valid, pix_data, pix_eol, pix_eof, frame_done
  );
endinterface

// File: rtl/dct_stripe_buffer.sv
// One 8-row image stripe: whole-block write by block column, single-pixel
// asynchronous read by (row, col).
module dct_stripe_buffer #(
  parameter int N     = 16,
  parameter int IMG_W = 128,
  parameter int COLW  = 7,
  parameter int BCW   = 4
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [BCW-1:0]  wr_bcol,
  input  logic [64*N-1:0] wr_blk,
  input  logic [2:0]      rd_row,
  input  logic [COLW-1:0] rd_col,
  output logic [N-1:0]    rd_data
);
  import dct_tile_pkg::*;

  logic [N-1:0]    row_q [BLK];
  logic [COLW-1:0] wr_base;

  assign wr_base = COLW'(wr_bcol) << 3;

  // Each block row lands in its own stripe row, eight columns wide.
  for (genvar gi = 0; gi < BLK; gi++) begin : g_row
    logic [N-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
      if (wr_en) begin
        for (int c = 0; c < BLK; c++) begin
          mem[wr_base + COLW'(c)] <= wr_blk[elem_idx(gi, c)*N +: N];
        end
      end
    end

    assign row_q[gi] = mem[rd_col];
  end

  assign rd_data = row_q[rd_row];

endmodule

// File: rtl/dct_block_reassembler.sv
// Collects a stripe of 8x8 blocks and replays it as a raster pixel stream.
// Define DCT_REASM_PINGPONG_EN for two stripe buffers so fill and drain overlap.
module dct_block_reassembler #(
  parameter int N     = dct_tile_pkg::N,
  parameter int IMG_W = dct_tile_pkg::BPR * dct_tile_pkg::BLK,
  parameter int IMG_H = dct_tile_pkg::STRIPES * dct_tile_pkg::BLK
) (
  input  logic clk,
  input  logic rst_n,
  dct_block_reassembler_if.slave bus
);
  import dct_tile_pkg::*;

  localparam int BPR_L = IMG_W / BLK;
  localparam int STR_L = IMG_H / BLK;
  localparam int COLW  = cw(IMG_W);
  localparam int BCW   = cw(BPR_L);
  localparam int SW    = cw(STR_L);
`ifdef DCT_REASM_PINGPONG_EN
  localparam int NBUF  = 2;
`else
  localparam int NBUF  = 1;
`endif

  state_t          state_reg, state_next;
  logic            ready_en_reg;
  logic [BCW-1:0]  blk_col_reg, blk_col_next;
  logic [2:0]      row_reg, row_next;
  logic [COLW-1:0] col_reg, col_next;
  logic [SW-1:0]   stripe_reg, stripe_next;
  logic            frame_done_reg, frame_done_next;
`ifdef DCT_REASM_PINGPONG_EN
  logic            wsel_reg, wsel_next, rsel_reg, rsel_next;
  logic [1:0]      full_reg, full_next;
`endif

  logic            wsel;
  logic            blk_ready_c, blk_hs, pix_hs;
  logic            last_blk, last_col, last_row, last_stripe, stripe_end, eof_now;
  logic [N-1:0]    rd_q [NBUF];
  logic [N-1:0]    pix_q;

  assign last_blk    = (blk_col_reg == BCW'(BPR_L - 1));
  assign last_col    = (col_reg == COLW'(IMG_W - 1));
  assign last_row    = (row_reg == 3'd7);
  assign last_stripe = (stripe_reg == SW'(STR_L - 1));
  assign blk_hs      = bus.blk_valid && blk_ready_c;
  assign pix_hs      = (state_reg == DRAIN) && bus.pix_ready;
  assign stripe_end  = pix_hs && last_col && last_row;
  assign eof_now     = last_col && last_row && last_stripe;

`ifdef DCT_REASM_PINGPONG_EN
  assign wsel  = wsel_reg;
  assign pix_q = rd_q[rsel_reg];
`else
  assign wsel  = 1'b0;
  assign pix_q = rd_q[0];
`endif

  for (genvar gi = 0; gi < NBUF; gi++) begin : g_buf
    dct_stripe_buffer #(
      .N     (N),
      .IMG_W (IMG_W),
      .COLW  (COLW),
      .BCW   (BCW)
    ) u_buf (
      .clk     (clk),
      .wr_en   (blk_hs && (wsel == 1'(gi))),
      .wr_bcol (blk_col_reg),
      .wr_blk  (bus.blk_data),
      .rd_row  (row_reg),
      .rd_col  (col_reg),
      .rd_data (rd_q[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FILL;
      ready_en_reg   <= 1'b0;
      blk_col_reg    <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      stripe_reg     <= '0;
      frame_done_reg <= 1'b0;
`ifdef DCT_REASM_PINGPONG_EN
      wsel_reg       <= 1'b0;
      rsel_reg       <= 1'b0;
      full_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      ready_en_reg   <= 1'b1;
      blk_col_reg    <= blk_col_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      stripe_reg     <= stripe_next;
      frame_done_reg <= frame_done_next;
`ifdef DCT_REASM_PINGPONG_EN
      wsel_reg       <= wsel_next;
      rsel_reg       <= rsel_next;
      full_reg       <= full_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    blk_col_next    = blk_col_reg;
    row_next        = row_reg;
    col_next        = col_reg;
    stripe_next     = stripe_reg;
    frame_done_next = pix_hs && eof_now;

    if (blk_hs) begin
      blk_col_next = last_blk ? '0 : blk_col_reg + BCW'(1);
    end
    if (pix_hs) begin
      col_next = last_col ? '0 : col_reg + COLW'(1);
      if (last_col) begin
        row_next = row_reg + 3'd1;
      end
      if (stripe_end) begin
        stripe_next = last_stripe ? '0 : stripe_reg + SW'(1);
      end
    end

`ifdef DCT_REASM_PINGPONG_EN
    wsel_next = wsel_reg;
    rsel_next = rsel_reg;
    full_next = full_reg;
    if (blk_hs && last_blk) begin
      full_next[wsel_reg] = 1'b1;
      wsel_next           = ~wsel_reg;
    end
    if (stripe_end) begin
      full_next[rsel_reg] = 1'b0;
      rsel_next           = ~rsel_reg;
    end
    // A buffer completing on the same cycle the other drains is picked up with no bubble.
    case (state_reg)
      FILL: begin
        if (full_reg[rsel_reg] || (blk_hs && last_blk && (wsel_reg == rsel_reg))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (stripe_end) begin
          state_next = (full_reg[~rsel_reg] || (blk_hs && last_blk && (wsel_reg != rsel_reg)))
                       ? DRAIN : FILL;
        end
      end
      default: state_next = FILL;
    endcase
`else
    case (state_reg)
      FILL:    if (blk_hs && last_blk) state_next = DRAIN;
      DRAIN:   if (stripe_end)         state_next = FILL;
      default: state_next = FILL;
    endcase
`endif
  end

  always_comb begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_eol   = 1'b0;
    bus.pix_eof   = 1'b0;
`ifdef DCT_REASM_PINGPONG_EN
    blk_ready_c   = ready_en_reg && !full_reg[wsel_reg];
`else
    blk_ready_c   = ready_en_reg && (state_reg == FILL);
`endif
    if (state_reg == DRAIN) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix_q;
      bus.pix_eol   = last_col;
      bus.pix_eof   = eof_now;
    end
  end

  assign bus.blk_ready  = blk_ready_c;
  assign bus.frame_done = frame_done_reg;

endmodule
